// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the instruction cache.
//   - FSM state encoding
//   - default significant address width
//   - instruction width
//   - memctrl word-request address width
package icache_pkg;

  localparam int unsigned ICACHE_ADDR_BITS = 18;
  localparam int unsigned INST_W           = 32;
  localparam int unsigned MEMREQ_ADDR_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } icache_state_e;

  // Fills are always whole words, so the request address drops the byte offset.
  function automatic logic [MEMREQ_ADDR_W-1:0] word_align(input logic [MEMREQ_ADDR_W-1:0] a);
    return {a[MEMREQ_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for a direct-mapped, one-word-per-line cache.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset (clears valid bits only)
//   rd_index_i, rd_tag_i   lookup address fields
//   hit_o, rd_data_o       combinational lookup result
//   we_i                   write strobe (caller already gates with global ready)
//   wr_index_i, wr_tag_i, wr_data_i  line to install
module icache_array #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 10,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  input  logic [TAG_BITS-1:0]   rd_tag_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]     wr_data_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are qualified by valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between IF and the memory controller.
// Ports:
//   clk_in, rst_in, rdy_in                  clock, async active-low reset, global ready
//   if_icache_en_in, if_icache_inst_addr_in fetch request from IF
//   icache_if_rdy_out, icache_if_miss_out,
//   icache_if_inst_inst_out                 registered response pulses to IF
//   icache_memctrl_en_out, _addr_out        word read request to memctrl
//   memctrl_icache_rdy_in, _inst_in         fill response
//   rob_icache_rst_in                       flush from ROB
//
// state | meaning
// IDLE  | accept fetches; hits answered next cycle
// FETCH | miss outstanding, response owed to IF
// DRAIN | miss outstanding after a flush; fill line, no response
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_BITS  = ICACHE_ADDR_BITS
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     if_icache_en_in,
  input  logic [31:0]              if_icache_inst_addr_in,
  output logic                     icache_if_rdy_out,
  output logic                     icache_if_miss_out,
  output logic [INST_W-1:0]        icache_if_inst_inst_out,
  output logic                     icache_memctrl_en_out,
  output logic [MEMREQ_ADDR_W-1:0] icache_memctrl_addr_out,
  input  logic                     memctrl_icache_rdy_in,
  input  logic [INST_W-1:0]        memctrl_icache_inst_in,
  input  logic                     rob_icache_rst_in
);

  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  icache_state_e state_q, state_d;

  logic                     rdy_q, rdy_d;
  logic                     miss_q, miss_d;
  logic [INST_W-1:0]        inst_q, inst_d;
  logic                     mem_en_q, mem_en_d;
  logic [MEMREQ_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                     fill_we;

  logic [INDEX_BITS-1:0] rd_index, wr_index;
  logic [TAG_BITS-1:0]   rd_tag, wr_tag;
  logic                  hit;
  logic [INST_W-1:0]     rd_data;

  assign rd_index = if_icache_inst_addr_in[INDEX_BITS+1:2];
  assign rd_tag   = if_icache_inst_addr_in[ADDR_BITS-1:INDEX_BITS+2];
  // The latched request address provides the fill location.
  assign wr_index = mem_addr_q[INDEX_BITS+1:2];
  assign wr_tag   = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_icache_inst_addr_in[31:ADDR_BITS], if_icache_inst_addr_in[1:0]};

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_W     (INST_W)
  ) u_array (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .rd_index_i (rd_index),
    .rd_tag_i   (rd_tag),
    .hit_o      (hit),
    .rd_data_o  (rd_data),
    .we_i       (fill_we && rdy_in),
    .wr_index_i (wr_index),
    .wr_tag_i   (wr_tag),
    .wr_data_i  (memctrl_icache_inst_in)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!rob_icache_rst_in && if_icache_en_in && !hit) state_d = FETCH;
      end
      FETCH: begin
        if (memctrl_icache_rdy_in)  state_d = IDLE;
        else if (rob_icache_rst_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (memctrl_icache_rdy_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d      = 1'b0;
    miss_d     = 1'b0;
    inst_d     = inst_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rob_icache_rst_in && if_icache_en_in) begin
          if (hit) begin
            rdy_d  = 1'b1;
            inst_d = rd_data;
          end else begin
            miss_d     = 1'b1;
            mem_en_d   = 1'b1;
            mem_addr_d = word_align(if_icache_inst_addr_in);
          end
        end
      end
      FETCH: begin
        if (memctrl_icache_rdy_in) begin
          fill_we  = 1'b1;
          mem_en_d = 1'b0;
          // A flush landing on the fill cycle still installs the line but suppresses the response.
          if (!rob_icache_rst_in) begin
            rdy_d  = 1'b1;
            inst_d = memctrl_icache_inst_in;
          end
        end
      end
      DRAIN: begin
        if (memctrl_icache_rdy_in) begin
          fill_we  = 1'b1;
          mem_en_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdy_q      <= 1'b0;
      miss_q     <= 1'b0;
      inst_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      rdy_q      <= rdy_d;
      miss_q     <= miss_d;
      inst_q     <= inst_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign icache_if_rdy_out       = rdy_q;
  assign icache_if_miss_out      = miss_q;
  assign icache_if_inst_inst_out = inst_q;
  assign icache_memctrl_en_out   = mem_en_q;
  assign icache_memctrl_addr_out = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        en;
  logic [31:0] addr;
  logic        rdy_out;
  logic        miss_out;
  logic [31:0] inst_out;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic [31:0] mem_inst;
  logic        flush;

  always #5 clk = ~clk;

  icache dut (
    .clk_in                  (clk),
    .rst_in                  (rst_n),
    .rdy_in                  (rdy),
    .if_icache_en_in         (en),
    .if_icache_inst_addr_in  (addr),
    .icache_if_rdy_out       (rdy_out),
    .icache_if_miss_out      (miss_out),
    .icache_if_inst_inst_out (inst_out),
    .icache_memctrl_en_out   (mem_en),
    .icache_memctrl_addr_out (mem_addr),
    .memctrl_icache_rdy_in   (mem_rdy),
    .memctrl_icache_inst_in  (mem_inst),
    .rob_icache_rst_in       (flush)
  );

  typedef struct packed {
    logic        is_miss;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rdy && (rdy_out || miss_out)) begin
      if (rdy_out && miss_out) begin
        checks++;
        errors++;
        $display("FAIL pulse_exclusive: rdy_out and miss_out both high at %0t", $time);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: rdy_out=%0d miss_out=%0d inst=0x%08h with none expected at %0t",
                 rdy_out, miss_out, inst_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_is_miss", {31'd0, miss_out}, {31'd0, mon_e.is_miss});
        if (!mon_e.is_miss) check("hit_inst", inst_out, mon_e.inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_hit(input logic [31:0] w);
    exp_q.push_back('{is_miss: 1'b0, inst: w});
  endtask

  task automatic expect_miss();
    exp_q.push_back('{is_miss: 1'b1, inst: 32'd0});
  endtask

  task automatic req(input logic [31:0] a);
    en   = 1'b1;
    addr = a;
    tick();
    en   = 1'b0;
  endtask

  task automatic fill(input logic [31:0] w);
    mem_rdy  = 1'b1;
    mem_inst = w;
    tick();
    mem_rdy  = 1'b0;
  endtask

  // Miss then immediate fill, used to preload lines.
  task automatic miss_fill(input logic [31:0] a, input logic [31:0] w);
    expect_miss();
    req(a);
    check("prefill_mem_addr", mem_addr, {a[31:2], 2'b00});
    expect_hit(w);
    fill(w);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; en = 1'b0; addr = '0;
    mem_rdy = 1'b0; mem_inst = '0; flush = 1'b0;
    tick();
    check("rst_rdy_out",   {31'd0, rdy_out},  32'd0);
    check("rst_miss_out",  {31'd0, miss_out}, 32'd0);
    check("rst_inst_out",  inst_out,          32'd0);
    check("rst_mem_en",    {31'd0, mem_en},   32'd0);
    check("rst_mem_addr",  mem_addr,          32'd0);
    rst_n = 1'b1;
    tick();

    // 1. cold miss then hit
    expect_miss();
    req(32'h0);
    check("t1_mem_en",   {31'd0, mem_en}, 32'd1);
    check("t1_mem_addr", mem_addr,        32'h0);
    tick(); tick();
    check("t1_mem_en_held", {31'd0, mem_en}, 32'd1);
    expect_hit(32'h0000_0093);
    fill(32'h0000_0093);
    check("t1_mem_en_drop", {31'd0, mem_en}, 32'd0);
    expect_hit(32'h0000_0093);
    req(32'h0);
    check("t1_hit_no_mem", {31'd0, mem_en}, 32'd0);

    // 2. conflict eviction on index 0
    miss_fill(32'h0000_0100, 32'hAAAA_0100);
    expect_miss();
    req(32'h0);
    check("t2_refetch_addr", mem_addr, 32'h0);
    expect_hit(32'h0000_0093);
    fill(32'h0000_0093);

    // 3. streaming hits; low address bits ignored on the request
    miss_fill(32'h0000_0007, 32'h1111_0004);
    miss_fill(32'h0000_0008, 32'h2222_0008);
    miss_fill(32'h0000_000C, 32'h3333_000C);
    expect_hit(32'h1111_0004);
    expect_hit(32'h2222_0008);
    expect_hit(32'h3333_000C);
    en = 1'b1;
    addr = 32'h4; tick();
    addr = 32'h8; tick();
    addr = 32'hC; tick();
    en = 1'b0;
    // bits above ADDR_BITS-1 ignored: aliases line 0x4
    expect_hit(32'h1111_0004);
    req(32'hFFFC_0004);
    check("t3_alias_no_mem", {31'd0, mem_en}, 32'd0);

    // 4. flush during fill: line installed, no response
    expect_miss();
    req(32'h0000_0040);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_drain_mem_en", {31'd0, mem_en}, 32'd1);
    tick(); tick();
    fill(32'h4444_0040);
    check("t4_drain_done", {31'd0, mem_en}, 32'd0);
    expect_hit(32'h4444_0040);
    req(32'h0000_0040);

    // 5. flush with same-cycle request in IDLE
    en = 1'b1; addr = 32'h0000_0200; flush = 1'b1;
    tick();
    en = 1'b0; flush = 1'b0;
    check("t5_no_rdy",    {31'd0, rdy_out},  32'd0);
    check("t5_no_miss",   {31'd0, miss_out}, 32'd0);
    check("t5_no_mem_en", {31'd0, mem_en},   32'd0);
    tick();
    check("t5_still_idle", {31'd0, mem_en}, 32'd0);

    // 6. rdy_in low mid-FETCH, then normal fill
    expect_miss();
    req(32'h0000_0080);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_frozen_en",   {31'd0, mem_en}, 32'd1);
      check("t6_frozen_addr", mem_addr,        32'h0000_0080);
    end
    rdy = 1'b1;
    tick();
    expect_hit(32'h5555_0080);
    fill(32'h5555_0080);
    expect_hit(32'h5555_0080);
    req(32'h0000_0080);

    // async reset mid-FETCH
    expect_miss();
    req(32'h0000_00C0);
    tick();
    check("t6_pre_rst_en", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem_en",   {31'd0, mem_en}, 32'd0);
    check("t6_rst_mem_addr", mem_addr,        32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // valid was cleared: a previously cached line misses again
    miss_fill(32'h0000_0080, 32'h6666_0080);

    tick(); tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache directly upstream of the IF stage.
- Serves IF fetch requests and fills misses with whole 32-bit words from the memory controller.
- Holds at most one outstanding request.
- On a ROB flush, abandons any response to IF but completes the in-flight memory transfer.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines).
- ADDR_BITS, 18, significant address bits (17:0).
- TAG_BITS, ADDR_BITS-INDEX_BITS-2, tag width (derived, not overridable).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state and outputs
- if_icache_en_in  input  1  IF fetch request, single-cycle
- if_icache_inst_addr_in  input  32  fetch PC, word aligned
- icache_if_rdy_out  output  1  one-cycle pulse: instruction valid
- icache_if_miss_out  output  1  one-cycle pulse: request missed, fill started
- icache_if_inst_inst_out  output  32  instruction, valid when rdy_out=1
- icache_memctrl_en_out  output  1  word read request, held until rdy
- icache_memctrl_addr_out  output  32  word address of fill
- memctrl_icache_rdy_in  input  1  one-cycle pulse: fill data valid
- memctrl_icache_inst_in  input  32  fill word
- rob_icache_rst_in  input  1  flush (mispredict), one cycle

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[ADDR_BITS-1:INDEX_BITS+2]
  - addr[1:0] ignored
  - bits above ADDR_BITS-1 ignored
- Storage: valid[2^INDEX_BITS], tag[], data[]. Hit = valid && tag match, combinational on the incoming address.
- Reset (rst_in=0, asynchronous):
  - state=IDLE, all valid=0
  - all outputs 0
  - latched address 0
- rdy_in=0: no register changes. Outputs hold their values; a pulse in flight stays high until rdy_in returns.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - flush=1: drop any same-cycle request; stay IDLE. Flush has priority over en.
  - en=1 && hit: next cycle rdy_out=1 and inst_out=data[index]; stay IDLE. Back-to-back hits sustain 1 instruction/cycle.
  - en=1 && miss:
    - next cycle miss_out=1 for one cycle
    - memctrl_en_out=1, memctrl_addr_out={addr[31:2],2'b00}
    - go to FETCH
  - en=0: rdy_out=0, miss_out=0.
- FETCH:
  - en_in ignored; IF must not issue until rdy_out.
  - memctrl_icache_rdy_in=1:
    - write valid/tag/data at the latched index
    - next cycle rdy_out=1 with inst_out=fill word
    - memctrl_en_out=0 on the same edge
    - go to IDLE
  - flush=1 without memctrl rdy: go to DRAIN; memctrl_en stays high.
  - flush=1 and memctrl rdy in the same cycle: fill the line; no rdy_out; go to IDLE.
- DRAIN:
  - en_in ignored; flush has no further effect.
  - On memctrl rdy: fill the line (data is correct for the latched address); rdy_out stays 0; memctrl_en drops; go to IDLE.
- memctrl_en_out/addr_out are registered and stable through FETCH/DRAIN. The memctrl must not raise rdy_in while en_out=0.
- rdy_out and miss_out are never both 1.
- inst_out holds its last value when rdy_out=0.
- Eviction: a fill overwrites the line unconditionally; there is no dirty state.
- Reset mid-FETCH clears en immediately. The memctrl is reset by the same rst_in.

Decomposition:
- Shared defines header:
  - state encodings (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2)
  - ADDR_BITS
  - instruction width 32
  - the memctrl word-request handshake width
- Sub-module icache_array: valid/tag/data storage.
  - Combinational hit and data read on index+tag.
  - Synchronous write port.
  - Asynchronous clear of valid on rst_in.
- The FSM and IF/memctrl handshakes stay in icache.

Test Plan:
1. Cold miss, then hit:
   - After reset, en with addr 0x0 -> miss_out=1 at +1; memctrl_en=1 with addr 0x0.
   - Memctrl rdy with 0x00000093 at +4 -> rdy_out=1 with inst 0x00000093 at +5.
   - en with 0x0 again -> rdy_out at +1; memctrl_en stays 0.
2. Conflict eviction (INDEX_BITS=6):
   - Fill 0x0000, then request 0x0100 (same index 0) -> miss and fill 0x0100's data.
   - Re-request 0x0000 -> miss again.
3. Streaming hits:
   - Prefill 0x4, 0x8, 0xC, then en on three consecutive cycles -> rdy_out three consecutive cycles with the matching words; miss_out never 1.
4. Flush during fill:
   - Miss on 0x40, flush at fill cycle 2, memctrl rdy at cycle 5 -> rdy_out never asserts; state returns to IDLE.
   - Subsequent request 0x40 -> hit at +1.
5. Flush with same-cycle request in IDLE -> no rdy_out, no miss_out, memctrl_en stays 0.
6. rdy_in low:
   - Hold rdy_in=0 for 3 cycles mid-FETCH -> en/addr/state unchanged.
   - Memctrl rdy arriving after rdy_in=1 -> normal fill.
   - Async reset asserted mid-FETCH -> memctrl_en=0 and all valid cleared immediately.
